// File: rtl/memory_read_mux_3ins.sv
// Read-return merge for the CPU data-memory interface.
// Each read request's region select travels as a tag through a pipeline
// that matches the memories' read latency; when the tag reaches the last
// stage, the matching region's read data is registered onto data_out.
module memory_read_mux_3ins #(
  parameter int                    DATA_WIDTH   = 16,
  parameter int                    READ_LATENCY = 2,   // legal range 1..4
  parameter logic [DATA_WIDTH-1:0] DEFAULT_DATA = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_req,
  input  logic [1:0]            rd_select,
  input  logic [DATA_WIDTH-1:0] data_in_0,
  input  logic [DATA_WIDTH-1:0] data_in_1,
  input  logic [DATA_WIDTH-1:0] data_in_2,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  sel_err,
  output logic                  busy,
  output logic [2:0]            outstanding
);

  localparam logic [1:0] SEL_REGION_0 = 2'b00;
  localparam logic [1:0] SEL_REGION_1 = 2'b01;
  localparam logic [1:0] SEL_REGION_2 = 2'b10;

  // Tag pipeline: stage 0 is the newest request, stage READ_LATENCY-1
  // lines up with the cycle in which the memories present its data.
  logic [READ_LATENCY-1:0] stage_valid;
  logic [1:0]              stage_sel [READ_LATENCY];

  logic       last_valid;
  logic [1:0] last_sel;

  assign last_valid = stage_valid[READ_LATENCY-1];
  assign last_sel   = stage_sel[READ_LATENCY-1];

  // Advance the valid bits every cycle; reset discards every in-flight tag.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its predecessor's value from before this edge.
    if (reset) begin
      stage_valid <= '0;
    end else begin
      stage_valid[0] <= rd_req;
      for (int k = 1; k < READ_LATENCY; k++) begin
        stage_valid[k] <= stage_valid[k-1];
      end
    end
  end

  // Advance the select payload; it only matters alongside a set valid bit.
  always_ff @(posedge clk) begin
    // NOTE: the select payload is deliberately not reset -- the valid bits
    // alone decide whether a stage means anything, so clearing them is enough.
    stage_sel[0] <= rd_select;
    for (int k = 1; k < READ_LATENCY; k++) begin
      stage_sel[k] <= stage_sel[k-1];
    end
  end

  // Register the region data selected by the retiring tag; hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      sel_err    <= 1'b0;
    end else begin
      data_valid <= last_valid;
      if (last_valid) begin
        case (last_sel)
          SEL_REGION_0: data_out <= data_in_0;
          SEL_REGION_1: data_out <= data_in_1;
          SEL_REGION_2: data_out <= data_in_2;
          default: begin
            data_out <= DEFAULT_DATA;
            sel_err  <= 1'b1;   // sticky until reset
          end
        endcase
      end
    end
  end

  // Count the valid tag stages to report requests still in flight.
  always_comb begin
    // NOTE: the count gets a default before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    outstanding = '0;
    for (int k = 0; k < READ_LATENCY; k++) begin
      outstanding = outstanding + {2'b00, stage_valid[k]};
    end
  end

  assign busy = (outstanding != 3'd0);

endmodule

// File: tb/tb_memory_read_mux_3ins.sv
// Self-checking bench for memory_read_mux_3ins: directed scenarios followed
// by random traffic, compared cycle by cycle against a history-based model.
module tb_memory_read_mux_3ins;

  localparam int              DW     = 16;
  localparam int              RL     = 2;
  localparam logic [DW-1:0]   DEF    = 16'h0000;
  localparam int              NCYC   = 700;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rd_req = 1'b0;
  logic [1:0]    rd_select = 2'b00;
  logic [DW-1:0] data_in_0 = '0;
  logic [DW-1:0] data_in_1 = '0;
  logic [DW-1:0] data_in_2 = '0;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          sel_err;
  logic          busy;
  logic [2:0]    outstanding;

  always #5 clk = ~clk;

  memory_read_mux_3ins #(
    .DATA_WIDTH  (DW),
    .READ_LATENCY(RL),
    .DEFAULT_DATA(DEF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rd_req     (rd_req),
    .rd_select  (rd_select),
    .data_in_0  (data_in_0),
    .data_in_1  (data_in_1),
    .data_in_2  (data_in_2),
    .data_out   (data_out),
    .data_valid (data_valid),
    .sel_err    (sel_err),
    .busy       (busy),
    .outstanding(outstanding)
  );

  int errors = 0;
  int checks = 0;

  // Input history per cycle: the model works purely from what was applied.
  bit            h_rst [NCYC];
  bit            h_req [NCYC];
  logic [1:0]    h_sel [NCYC];
  logic [DW-1:0] h_din [NCYC][3];
  int            cyc = 0;

  // Model state that persists across cycles.
  logic [DW-1:0] m_data = '0;
  bit            m_err  = 1'b0;

  function automatic bit rst_at(int j);
    return (j < 0) ? 1'b1 : h_rst[j];
  endfunction

  function automatic bit req_at(int j);
    return (j < 0) ? 1'b0 : h_req[j];
  endfunction

  // A request issued in cycle j survives to cycle c if no reset occurred
  // in any cycle from j through c-1.
  function automatic bit alive(int j, int c);
    bit ok;
    ok = req_at(j);
    for (int k = j; k < c; k++) if (rst_at(k)) ok = 1'b0;
    return ok;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  // Expected outputs during cycle cyc, derived from the input history.
  task automatic check_cycle();
    int         c;
    int         rj;
    bit         retire;
    int         outst;
    logic [1:0] s;
    c      = cyc;
    rj     = c - RL - 1;            // request cycle whose result appears now
    retire = alive(rj, c);
    if (rst_at(c - 1)) begin
      m_data = '0;
      m_err  = 1'b0;
    end else if (retire) begin
      s = h_sel[rj];
      if (s == 2'b11) begin
        m_data = DEF;
        m_err  = 1'b1;
      end else begin
        m_data = h_din[c-1][int'(s)];  // memory data presented RL cycles after the request
      end
    end
    outst = 0;
    for (int j = c - RL; j < c; j++) if (alive(j, c)) outst++;
    check("data_valid",  32'(data_valid),  32'(retire));
    check("data_out",    32'(data_out),    32'(m_data));
    check("sel_err",     32'(sel_err),     32'(m_err));
    check("outstanding", 32'(outstanding), 32'(outst));
    check("busy",        32'(busy),        32'(outst != 0));
  endtask

  // One cycle: check current outputs, then apply and record this cycle's inputs.
  task automatic step(input bit r, input bit q, input logic [1:0] s,
                      input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] d);
    @(posedge clk);
    #1;
    if (cyc >= NCYC) begin
      $display("FAIL history_overflow cycle=%0d got=%0d expected<%0d", cyc, cyc, NCYC);
      $fatal(1, "history overflow");
    end
    check_cycle();
    reset = r; rd_req = q; rd_select = s;
    data_in_0 = a; data_in_1 = b; data_in_2 = d;
    h_rst[cyc] = r; h_req[cyc] = q; h_sel[cyc] = s;
    h_din[cyc][0] = a; h_din[cyc][1] = b; h_din[cyc][2] = d;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'b00, 16'h5A5A, 16'hA5A5, 16'h3C3C);
  endtask

  initial begin
    // Reset, then a quiet period.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'b00, '0, '0, '0);
    idle(10);

    // Single read from region 1.
    step(1'b0, 1'b1, 2'b01, 16'h1111, 16'h1111, 16'h1111);
    step(1'b0, 1'b0, 2'b00, 16'h1111, 16'h1111, 16'h1111);
    step(1'b0, 1'b0, 2'b00, 16'h1111, 16'hBEEF, 16'h1111);
    idle(3);

    // Back-to-back reads across all three regions.
    step(1'b0, 1'b1, 2'b00, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    step(1'b0, 1'b1, 2'b01, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    step(1'b0, 1'b1, 2'b10, 16'h000A, 16'hEEEE, 16'hEEEE);
    step(1'b0, 1'b0, 2'b00, 16'hDDDD, 16'h000B, 16'hDDDD);
    step(1'b0, 1'b0, 2'b00, 16'hCCCC, 16'hCCCC, 16'h000C);
    idle(3);

    // Illegal select, then a legal read; the error flag must stick.
    step(1'b0, 1'b1, 2'b11, 16'h7777, 16'h7777, 16'h7777);
    idle(3);
    step(1'b0, 1'b1, 2'b01, 16'h0101, 16'h0202, 16'h0303);
    step(1'b0, 1'b0, 2'b00, 16'h0101, 16'h0202, 16'h0303);
    step(1'b0, 1'b0, 2'b00, 16'h9999, 16'h1234, 16'h9999);
    idle(3);

    // Reset while two requests are in flight.
    step(1'b0, 1'b1, 2'b00, 16'h4444, 16'h4444, 16'h4444);
    step(1'b0, 1'b1, 2'b10, 16'h4444, 16'h4444, 16'h4444);
    step(1'b1, 1'b0, 2'b00, 16'h4444, 16'h4444, 16'h4444);
    idle(5);

    // Requests held high during reset must be ignored.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 2'b01, 16'h6666, 16'h6666, 16'h6666);
    idle(4);

    // Random traffic with occasional resets and illegal selects.
    for (int i = 0; i < 450; i++) begin
      step(($urandom_range(0, 59) == 0),
           ($urandom_range(0, 9) < 7),
           2'($urandom_range(0, 3)),
           DW'($urandom), DW'($urandom), DW'($urandom));
    end
    idle(RL + 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
